// File: rtl/fp_issue_stage.sv
// Issue/sequencing stage in front of the combinational 16-bit FPU: registers one
// operation, holds it stable for a per-class settle window, then presents the result.
package ibex_pkg;
  typedef enum logic [1:0] {
    FP_ALU_ADD = 2'd0,
    FP_ALU_SUB = 2'd1,
    FP_ALU_MUL = 2'd2,
    FP_ALU_MAC = 2'd3
  } fp_alu_op_e;
endpackage

module fp_issue_stage import ibex_pkg::*; #(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  fp_alu_op_e       req_op_i,
  input  logic [15:0]      req_a_i,
  input  logic [15:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output fp_alu_op_e       fpu_op_o,
  output logic [15:0]      fpu_a_o,
  output logic [15:0]      fpu_b_o,
  input  logic [15:0]      fpu_result_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [15:0]      resp_result_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef struct packed {
    fp_alu_op_e       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e      state;
  req_t        held;
  logic [3:0]  cnt;
  logic [15:0] result;
  logic        accept;

  assign req_ready_o = (state == IDLE) | ((state == DONE) & resp_ready_i);
  assign accept      = req_valid_i & req_ready_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      held   <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush_i) begin
      // operand/result registers deliberately keep their values
      state <= IDLE;
    end else begin
      case (state)
        IDLE: ;
        EXEC:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            result <= fpu_result_i;
            state  <= DONE;
          end
        DONE: if (resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      // a new accept (IDLE or consuming DONE) overrides the case above
      if (accept) begin
        held.op  <= req_op_i;
        held.a   <= req_a_i;
        held.b   <= req_b_i;
        held.tag <= req_tag_i;
        cnt      <= (req_op_i inside {FP_ALU_ADD, FP_ALU_SUB}) ? ADD_CNT : MUL_CNT;
        state    <= EXEC;
      end
    end
  end

  assign fpu_op_o      = held.op;
  assign fpu_a_o       = held.a;
  assign fpu_b_o       = held.b;
  assign resp_tag_o    = held.tag;
  assign resp_result_o = result;
  assign resp_valid_o  = (state == DONE);
  assign busy_o        = (state != IDLE);

endmodule

// File: doc/fp_issue_stage.md
# fp_issue_stage

Request/response sequencing stage placed directly upstream of the combinational 16-bit FPU. Accepts one FP operation at a time from the core over a valid/ready handshake and registers the operator and operands. Drives them stably into the FPU for a per-class multicycle settle window, captures the FPU result and holds it on a valid/ready response port until consumed. Provides back-to-back issue, a flush path, and a busy indication for the core's stall logic.

## Interface
Parameters:
- ADD_LAT, 1, settle cycles for FP_ALU_ADD / FP_ALU_SUB (legal range 1..15)
- MUL_LAT, 2, settle cycles for every other fp_alu_op_e encoding, i.e. the multiply class (legal range 1..15)
- TAG_W, 5, width of the destination tag carried alongside the operation

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- flush_i  in  1  kill any in-flight or held operation
- req_valid_i  in  1  request present
- req_ready_o  out  1  stage can accept a request this cycle
- req_op_i  in  ibex_pkg::fp_alu_op_e  requested operator
- req_a_i, req_b_i  in  16 each  operands
- req_tag_i  in  TAG_W  destination tag
- fpu_op_o  out  fp_alu_op_e  registered operator to FPU
- fpu_a_o, fpu_b_o  out  16 each  registered operands to FPU
- fpu_result_i  in  16  FPU combinational result
- resp_valid_o  out  1  result held and valid
- resp_ready_i  in  1  consumer takes result
- resp_result_o  out  16  captured result
- resp_tag_o  out  TAG_W  tag of that result
- busy_o  out  1  high in EXEC or DONE

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state IDLE.
- Accept = req_valid_i & req_ready_o & ~flush_i.
- req_ready_o = (state==IDLE) | (state==DONE & resp_ready_i); combinational, independent of req_valid_i.
- On accept: load op/a/b/tag registers; load counter with LAT-1 (ADD_LAT if op is FP_ALU_ADD or FP_ALU_SUB, else MUL_LAT); go EXEC.
- EXEC: counter nonzero -> decrement. Counter zero -> capture fpu_result_i into result register, go DONE.
- DONE: resp_valid_o=1. resp_ready_i=1 with accept -> EXEC with new operation. resp_ready_i=1 without accept -> IDLE. resp_ready_i=0 -> stay; result/tag stable.
- fpu_op_o/fpu_a_o/fpu_b_o change only on accept; stable through EXEC and DONE.
- flush_i (any state): next state IDLE, resp_valid_o low next cycle, no accept that cycle, no result capture; operand registers keep their values.
- rst_i overrides flush_i and everything else.
- Counter width 4 bits; no wrap, since LAT-1 ≤ 14.

## Timing
- Reset values: req_ready_o=1 (IDLE), resp_valid_o=0, busy_o=0, fpu_op_o=FP_ALU_ADD, fpu_a_o/fpu_b_o=0, resp_result_o=0, resp_tag_o=0.
- Accept at edge k -> FPU inputs valid from edge k. Result captured at edge k+LAT. resp_valid_o high from edge k+LAT.
- ADD_LAT=1: request cycle, one EXEC cycle, then resp_valid_o.
- Back-to-back: response consumed and new request accepted at the same edge. One op completes every LAT+1 cycles with no idle bubble.
- Reset or flush asserted mid-EXEC: the FSM is IDLE at the next edge and the pending result is never presented.
- busy_o is registered-state decoded, so it carries no combinational path from inputs.

## Test plan
- Reset: hold rst_i 2 cycles -> all outputs at reset values. Release -> req_ready_o=1, resp_valid_o=0.
- Add issue: ADD_LAT=1, op FP_ALU_ADD, a=0x3F80, b=0x4000, tag=3, FPU model returns 0x4040 -> resp_valid_o 2 edges after request, result 0x4040, tag 3; req_ready_o=0 during EXEC.
- Multiply latency: MUL_LAT=3, a=0x4000, b=0x4040, model 0x40C0 -> exactly 3 EXEC cycles. fpu_a_o/fpu_b_o unchanged throughout; resp_result_o=0x40C0.
- Backpressure: resp_ready_i low 5 cycles in DONE -> resp_valid_o, result and tag stable; req_ready_o=0. Raise resp_ready_i with a new req_valid_i -> both handshakes at the same edge; state EXEC next.
- Flush: flush_i pulse in the 2nd EXEC cycle of a MUL_LAT=3 op -> IDLE next edge, resp_valid_o never rises. A simultaneous req_valid_i is not accepted.
- Stream: 8 alternating add/mul requests with resp_ready_i=1 -> results in order, tags 0..7 match, no bubbles beyond LAT+1 spacing.
